// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer. Steers an external round-key register through
// load / forward / reverse expansion so a consumer sees round keys 0..10 (encrypt)
// or 10..0 (decrypt), one round per accepted step.
module aes_key_sched_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic       step,
    input  logic       abort,
    output logic [1:0] ks_ctrl,
    output logic [3:0] ks_round,
    output logic [3:0] round_idx,
    output logic       key_rdy,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LastRound   = 4'd10;
    localparam logic [1:0] CtrlHold    = 2'b00;
    localparam logic [1:0] CtrlLoad    = 2'b01;
    localparam logic [1:0] CtrlForward = 2'b10;
    localparam logic [1:0] CtrlReverse = 2'b11;

    typedef enum logic [1:0] {StIdle, StLoad, StPrecomp, StServe} state_e;

    state_e     state_q, state_d;
    logic       mode_q, mode_d;
    logic [3:0] round_q, round_d;
    logic       done_q, done_d;

    // State, captured mode, current key round and the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            round_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic and scheduler steering; the scheduler captures on the same edge
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        round_d  = round_q;
        done_d   = 1'b0;
        ks_ctrl  = CtrlHold;
        ks_round = 4'd0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = mode;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                ks_ctrl = CtrlLoad;
                round_d = 4'd0;
                state_d = mode_q ? StPrecomp : StServe;
            end
            StPrecomp: begin
                // Walk forward to the round-10 key before serving in decrypt order
                ks_ctrl  = CtrlForward;
                ks_round = round_q + 4'd1;
                round_d  = round_q + 4'd1;
                if (round_q == LastRound - 4'd1) begin
                    state_d = StServe;
                end
            end
            StServe: begin
                if (step) begin
                    if (!mode_q && round_q < LastRound) begin
                        ks_ctrl  = CtrlForward;
                        ks_round = round_q + 4'd1;
                        round_d  = round_q + 4'd1;
                    end else if (mode_q && round_q != 4'd0) begin
                        // Reverse expansion from round r uses the rcon of round r
                        ks_ctrl  = CtrlReverse;
                        ks_round = round_q;
                        round_d  = round_q - 4'd1;
                    end else begin
                        state_d = StIdle;
                        round_d = 4'd0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides any step or transition decided above
        if (abort && state_q != StIdle) begin
            ks_ctrl  = CtrlHold;
            ks_round = 4'd0;
            state_d  = StIdle;
            round_d  = 4'd0;
            done_d   = 1'b0;
        end
    end

    assign round_idx = round_q;
    assign key_rdy   = (state_q == StServe);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl with a behavioural AES-128 key scheduler
// attached, so the steering can be checked against real FIPS-197 round keys.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] Key0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] Key10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    logic       clk, rst_n, start, mode, step, abort;
    logic [1:0] ks_ctrl;
    logic [3:0] ks_round, round_idx;
    logic       key_rdy, busy, done;

    aes_key_sched_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .step     (step),
        .abort    (abort),
        .ks_ctrl  (ks_ctrl),
        .ks_round (ks_round),
        .round_idx(round_idx),
        .key_rdy  (key_rdy),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES-128 key expansion model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] rcon_word(input logic [3:0] r);
        logic [7:0] c = 8'h01;
        for (int i = 1; i < int'(r); i++) c = xtime(c);
        return {c, 24'h0};
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ rcon_word(r);
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] key_rev(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3) ^ rcon_word(r);
        return {w0, w1, w2, w3};
    endfunction

    logic [127:0] sched_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sched_key <= '0;
        else begin
            case (ks_ctrl)
                2'b01:   sched_key <= Key0;
                2'b10:   sched_key <= key_fwd(sched_key, ks_round);
                2'b11:   sched_key <= key_rev(sched_key, ks_round);
                default: sched_key <= sched_key;
            endcase
        end
    end

    // ---------------- checking and scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    string phase = "reset";

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0] ctrl;
        logic [3:0] kr;
        logic [3:0] ri;
        logic       rdy;
        logic       bsy;
        logic       dn;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Outputs are compared mid-cycle against the expectation queued for that cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check({phase, "/ks_ctrl"},   ks_ctrl,   mon_e.ctrl);
            check({phase, "/ks_round"},  ks_round,  mon_e.kr);
            check({phase, "/round_idx"}, round_idx, mon_e.ri);
            check({phase, "/key_rdy"},   key_rdy,   mon_e.rdy);
            check({phase, "/busy"},      busy,      mon_e.bsy);
            check({phase, "/done"},      done,      mon_e.dn);
        end
    end

    // Drive one cycle of inputs and queue the outputs required during that cycle
    task automatic cyc(input logic s, input logic m, input logic st, input logic ab,
                       input logic [1:0] c, input logic [3:0] kr, input logic [3:0] ri,
                       input logic rdy, input logic bsy, input logic dn);
        exp_t e;
        start = s;
        mode  = m;
        step  = st;
        abort = ab;
        e = '{ctrl: c, kr: kr, ri: ri, rdy: rdy, bsy: bsy, dn: dn};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc(input logic dn);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, dn);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/ks_ctrl"},   ks_ctrl,   2'b00);
        check({tag, "/ks_round"},  ks_round,  4'd0);
        check({tag, "/round_idx"}, round_idx, 4'd0);
        check({tag, "/key_rdy"},   key_rdy,   1'b0);
        check({tag, "/busy"},      busy,      1'b0);
        check({tag, "/done"},      done,      1'b0);
    endtask

    initial begin
        logic [127:0] k;
        int           ri;
        int           gaps;
        logic         s;

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        step  = 1'b0;
        abort = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cyc(1'b0);

        // Encrypt: step every cycle; mode wiggles after capture and must be ignored
        phase = "enc";
        cyc(1, 0, 0, 0, 2'b00, 4'd0, 4'd0, 0, 0, 0);
        cyc(0, 1, 0, 0, 2'b01, 4'd0, 4'd0, 0, 1, 0);
        check("enc_key0", sched_key, Key0);
        for (int r = 0; r < 10; r++) cyc(0, 1, 1, 0, 2'b10, 4'(r + 1), 4'(r), 1, 1, 0);
        check("enc_key10", sched_key, Key10);
        cyc(0, 0, 1, 0, 2'b00, 4'd0, 4'd10, 1, 1, 0);
        idle_cyc(1'b1);
        idle_cyc(1'b0);

        // Decrypt: 1 load + 10 precompute cycles (step ignored), then reverse to round 0
        phase = "dec";
        cyc(1, 1, 0, 0, 2'b00, 4'd0, 4'd0, 0, 0, 0);
        cyc(0, 0, 1, 0, 2'b01, 4'd0, 4'd0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 2'b10, 4'(i + 1), 4'(i), 0, 1, 0);
        check("dec_key10", sched_key, Key10);
        for (int r = 10; r > 0; r--) cyc(0, 0, 1, 0, 2'b11, 4'(r), 4'(r), 1, 1, 0);
        check("dec_key0", sched_key, Key0);
        cyc(0, 0, 1, 0, 2'b00, 4'd0, 4'd0, 1, 1, 0);
        idle_cyc(1'b1);
        idle_cyc(1'b0);

        // Stalled consumer with random gaps; start and mode are noise while busy
        phase = "stall";
        cyc(1, 0, 0, 0, 2'b00, 4'd0, 4'd0, 0, 0, 0);
        cyc(0, 1, 1, 0, 2'b01, 4'd0, 4'd0, 0, 1, 0);
        ri   = 0;
        gaps = 0;
        while (1) begin
            s = (gaps >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            if (!s) begin
                k = sched_key;
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0,
                    2'b00, 4'd0, 4'(ri), 1, 1, 0);
                check("stall_key_held", sched_key, k);
                gaps++;
            end else if (ri < 10) begin
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0,
                    2'b10, 4'(ri + 1), 4'(ri), 1, 1, 0);
                ri++;
                gaps = 0;
            end else begin
                check("stall_key10", sched_key, Key10);
                cyc(1, 1, 1, 0, 2'b00, 4'd0, 4'd10, 1, 1, 0);
                break;
            end
        end
        idle_cyc(1'b1);
        idle_cyc(1'b0);

        // Abort during the fifth precompute cycle
        phase = "abort_pre";
        cyc(1, 1, 0, 0, 2'b00, 4'd0, 4'd0, 0, 0, 0);
        cyc(0, 1, 0, 0, 2'b01, 4'd0, 4'd0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 2'b10, 4'(i + 1), 4'(i), 0, 1, 0);
        cyc(0, 1, 1, 1, 2'b00, 4'd0, 4'd4, 0, 1, 0);
        idle_cyc(1'b0);
        idle_cyc(1'b0);

        // Abort in SERVE at round 4, together with a step
        phase = "abort_srv";
        cyc(1, 0, 0, 0, 2'b00, 4'd0, 4'd0, 0, 0, 0);
        cyc(0, 0, 0, 0, 2'b01, 4'd0, 4'd0, 0, 1, 0);
        for (int r = 0; r < 4; r++) cyc(0, 0, 1, 0, 2'b10, 4'(r + 1), 4'(r), 1, 1, 0);
        k = sched_key;
        cyc(0, 0, 1, 1, 2'b00, 4'd0, 4'd4, 1, 1, 0);
        check("abort_srv_key_held", sched_key, k);
        idle_cyc(1'b0);
        idle_cyc(1'b0);

        // Reset pulse mid-SERVE: outputs drop at once, and a fresh start is needed after
        phase = "rst_mid";
        cyc(1, 0, 0, 0, 2'b00, 4'd0, 4'd0, 0, 0, 0);
        cyc(0, 0, 0, 0, 2'b01, 4'd0, 4'd0, 0, 1, 0);
        for (int r = 0; r < 3; r++) cyc(0, 0, 1, 0, 2'b10, 4'(r + 1), 4'(r), 1, 1, 0);
        start = 1'b1;
        step  = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 1, 0, 2'b00, 4'd0, 4'd0, 0, 0, 0);
        cyc(0, 0, 1, 0, 2'b00, 4'd0, 4'd0, 0, 0, 0);
        cyc(1, 0, 0, 0, 2'b00, 4'd0, 4'd0, 0, 0, 0);
        cyc(0, 0, 0, 0, 2'b01, 4'd0, 4'd0, 0, 1, 0);
        cyc(0, 0, 0, 0, 2'b00, 4'd0, 4'd0, 1, 1, 0);
        cyc(0, 0, 0, 1, 2'b00, 4'd0, 4'd0, 1, 1, 0);
        idle_cyc(1'b0);

        check("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 SHALL have the port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have the port start, input, 1 bit: begin a key session; sampled only in IDLE.
REQ-004 SHALL have the port mode, input, 1 bit: 0 = encrypt order (rounds 0..10), 1 = decrypt order (rounds 10..0); captured with start.
REQ-005 SHALL have the port step, input, 1 bit: consumer has used the current round key and requests the next one.
REQ-006 SHALL have the port abort, input, 1 bit: terminate the session.
REQ-007 SHALL have the port ks_ctrl, output, 2 bits: key-scheduler mux select: 00 hold, 01 load, 10 forward, 11 reverse.
REQ-008 SHALL have the port ks_round, output, 4 bits: round number to the scheduler's expansion logic.
REQ-009 SHALL have the port round_idx, output, 4 bits: round index of the key currently held in the scheduler register.
REQ-010 SHALL have the port key_rdy, output, 1 bit: the scheduler register holds a valid key for round_idx.
REQ-011 SHALL have the port busy, output, 1 bit: a session is in progress (state not IDLE).
REQ-012 SHALL have the port done, output, 1 bit: one-cycle pulse after the final key is consumed.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, PRECOMP, SERVE.
REQ-014 SHALL drive ks_ctrl and ks_round combinationally from state, step and round_idx; the scheduler captures on the same edge.
REQ-015 IDLE: ks_ctrl=00, ks_round=0. start=1 -> capture mode; next state LOAD.
REQ-016 LOAD (one cycle): ks_ctrl=01, ks_round=0; round_idx<=0. Next state SERVE if mode=0, PRECOMP if mode=1.
REQ-017 PRECOMP: ks_ctrl=10, ks_round=round_idx+1; round_idx increments each cycle; after the cycle with ks_round=10, round_idx=10 and next state is SERVE (exactly 10 cycles).
REQ-018 SERVE: key_rdy=1; without step, ks_ctrl=00 and round_idx is held.
REQ-019 SERVE encrypt, step=1, round_idx<10: ks_ctrl=10, ks_round=round_idx+1; round_idx<=round_idx+1.
REQ-020 SERVE decrypt, step=1, round_idx>0: ks_ctrl=11, ks_round=round_idx; round_idx<=round_idx-1.
REQ-021 Final step (encrypt at round_idx=10, decrypt at round_idx=0): ks_ctrl=00; next state IDLE; done=1 for the following cycle only.
REQ-022 SERVE SHALL accept back-to-back steps, one round per cycle.
REQ-023 Latency from start sampled to key_rdy: 2 cycles for encrypt; 12 cycles for decrypt.
REQ-024 SHALL ignore start when not in IDLE.
REQ-025 SHALL ignore step when not in SERVE.
REQ-026 SHALL ignore mode changes outside the start capture.
REQ-027 abort=1 in any non-IDLE state -> ks_ctrl=00 that cycle; next state IDLE; round_idx<=0; no done pulse.
REQ-028 abort SHALL take priority over step and over state transitions.
REQ-029 key_rdy=0 and busy=1 in LOAD and PRECOMP.
REQ-030 busy=0 and key_rdy=0 in IDLE.
REQ-031 round_idx SHALL never leave the range 0..10; there is no wrap-around.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, round_idx=0, mode register=0, done=0, key_rdy=0, busy=0, ks_ctrl=00, ks_round=0.
REQ-033 Reset asserted mid-session SHALL discard the session; after release, a new start SHALL be required.

Verification
REQ-034 Encrypt, with the scheduler attached and the FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c: start, then step every cycle -> round_idx 0..10 on consecutive cycles; round-10 key d014f9a8 c9ee2589 e13f0cc8 b6630ca6; done pulse one cycle after the 11th step.
REQ-035 Decrypt, same key: start -> ks_ctrl 01 for 1 cycle, then 10 for 10 cycles with ks_round 1..10; key_rdy at cycle 12 with round_idx=10; reverse steps reach round_idx=0 with key 2b7e1516..09cf4f3c.
REQ-036 Stalled consumer: step toggles with random gaps -> ks_ctrl=00 on every gap cycle; key is unchanged across gaps.
REQ-037 abort at PRECOMP cycle 5, and separately in SERVE at round_idx=4 -> IDLE next cycle; ks_ctrl=00; no done pulse.
REQ-038 rst_n pulsed low mid-SERVE -> all outputs at reset values immediately; start asserted while busy -> no effect.
